airi5c_wb_arbiter: RTL



---
 rtl/airi5c_wb_arbiter_pkg.sv | 26 ++
 rtl/airi5c_rr_arb.sv | 36 +++
 rtl/airi5c_wb_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/airi5c_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : airi5c_wb_arbiter_pkg
//  Description : Shared widths, parameter defaults and helpers for the
//                register-file write-back arbiter and its round-robin core.
//  Revision    : 1.0 - initial release
// ============================================================================
package airi5c_wb_arbiter_pkg;

    // Datapath widths of the RV32 core
    localparam int c_XPR_LEN        = 32;
    localparam int c_REG_ADDR_WIDTH = 5;
    localparam int c_NUM_REGS       = 32;

    // Architecture option defaults
    localparam int c_NUM_LL_DEFAULT       = 2;
    localparam int c_STARVE_LIMIT_DEFAULT = 4;

    // Pointer width for an n-way round-robin; a single requester still
    // needs a one-bit pointer so the port is never zero width.
    function automatic int rr_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/airi5c_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : airi5c_rr_arb
//  Description : Combinational round-robin arbiter. The pointer names the
//                highest-priority requester; the search wraps modulo N.
//                Produces a one-hot grant and the pointer that follows it.
//  Revision    : 1.0 - initial release
// ============================================================================
module airi5c_rr_arb
    import airi5c_wb_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = rr_ptr_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] next_ptr_o
);

    // Scan from the farthest offset down to the pointer so the nearest
    // requester after the pointer is the one left standing.
    always_comb begin
        gnt_o      = '0;
        next_ptr_o = ptr_i;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                gnt_o                            = '0;
                gnt_o[(int'(ptr_i) + k) % N]     = 1'b1;
                next_ptr_o = PTR_W'((int'(ptr_i) + k + 1) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/airi5c_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : airi5c_wb_arbiter
//  Description : Arbitrates the register file's single write port between
//                the in-order write-back stage and NUM_LL out-of-order
//                long-latency units, with a starvation guard that stalls
//                the pipeline, plus a GPR/FPR pending-result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module airi5c_wb_arbiter
    import airi5c_wb_arbiter_pkg::*;
#(
    parameter int NUM_LL       = c_NUM_LL_DEFAULT,
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               pl_wen_i,
    input  logic [c_REG_ADDR_WIDTH-1:0]        pl_wa_i,
    input  logic [c_XPR_LEN-1:0]               pl_wd_i,
    input  logic [c_XPR_LEN-1:0]               pl_wd2_i,
    input  logic                               pl_use_rd64_i,
    input  logic                               pl_fpu_i,
    input  logic [NUM_LL-1:0]                  ll_valid_i,
    output logic [NUM_LL-1:0]                  ll_ready_o,
    input  logic [NUM_LL*c_REG_ADDR_WIDTH-1:0] ll_wa_i,
    input  logic [NUM_LL*c_XPR_LEN-1:0]        ll_wd_i,
    input  logic [NUM_LL-1:0]                  ll_fpu_i,
    input  logic                               iss_valid_i,
    input  logic [c_REG_ADDR_WIDTH-1:0]        iss_wa_i,
    input  logic                               iss_fpu_i,
    input  logic                               dm_wen_i,
    output logic                               stall_o,
    output logic                               wen_o,
    output logic [c_REG_ADDR_WIDTH-1:0]        wa_o,
    output logic [c_XPR_LEN-1:0]               wd_o,
    output logic [c_XPR_LEN-1:0]               wd2_o,
    output logic                               use_rd64_o,
    output logic                               sel_fpu_rd_o,
    output logic [c_NUM_REGS-1:0]              gpr_pend_o,
    output logic [c_NUM_REGS-1:0]              fpr_pend_o
);

    localparam int c_PTR_W = rr_ptr_width(NUM_LL);

    logic [c_PTR_W-1:0]          r_rr_ptr;
    logic [3:0]                  r_starve_cnt;
    logic                        r_stall;
    logic [c_NUM_REGS-1:0]       r_gpr_pend;
    logic [c_NUM_REGS-1:0]       r_fpr_pend;

    logic [NUM_LL-1:0]           w_gnt;
    logic [c_PTR_W-1:0]          w_next_ptr;
    logic                        w_any_valid;
    logic                        w_pl_grant;
    logic                        w_ll_grant;
    logic [c_REG_ADDR_WIDTH-1:0] w_ll_wa;
    logic [c_XPR_LEN-1:0]        w_ll_wd;
    logic                        w_ll_fpu;
    logic [3:0]                  w_cnt_next;
    logic                        w_stall_next;
    logic [c_NUM_REGS-1:0]       w_gpr_set;
    logic [c_NUM_REGS-1:0]       w_fpr_set;
    logic [c_NUM_REGS-1:0]       w_gpr_clr;
    logic [c_NUM_REGS-1:0]       w_fpr_clr;

    airi5c_rr_arb #(
        .N     (NUM_LL),
        .PTR_W (c_PTR_W)
    ) u_rr_arb (
        .req_i      (ll_valid_i),
        .ptr_i      (r_rr_ptr),
        .gnt_o      (w_gnt),
        .next_ptr_o (w_next_ptr)
    );

    // Ownership: debug > unstalled pipeline > round-robin LL winner
    assign w_any_valid = |ll_valid_i;
    assign w_pl_grant  = !dm_wen_i && pl_wen_i && !r_stall;
    assign w_ll_grant  = !dm_wen_i && !w_pl_grant && w_any_valid;

    // Pick out the destination, data and file select of the LL winner
    always_comb begin
        w_ll_wa  = '0;
        w_ll_wd  = '0;
        w_ll_fpu = 1'b0;
        for (int i = 0; i < NUM_LL; i++) begin
            if (w_gnt[i]) begin
                w_ll_wa  = ll_wa_i[i*c_REG_ADDR_WIDTH +: c_REG_ADDR_WIDTH];
                w_ll_wd  = ll_wd_i[i*c_XPR_LEN +: c_XPR_LEN];
                w_ll_fpu = ll_fpu_i[i];
            end
        end
    end

    // Drive the register-file write port; enables are killed during reset
    always_comb begin
        wen_o        = rst_ni && (w_pl_grant || w_ll_grant);
        ll_ready_o   = (rst_ni && w_ll_grant) ? w_gnt : '0;
        wa_o         = w_pl_grant ? pl_wa_i  : w_ll_wa;
        wd_o         = w_pl_grant ? pl_wd_i  : w_ll_wd;
        wd2_o        = w_pl_grant ? pl_wd2_i : '0;
        use_rd64_o   = w_pl_grant && pl_use_rd64_i;
        sel_fpu_rd_o = w_pl_grant ? pl_fpu_i : w_ll_fpu;
    end

    // Starvation counter: a debug write freezes it; reaching the limit
    // raises a one-cycle stall and restarts the count.
    always_comb begin
        w_cnt_next   = r_starve_cnt;
        w_stall_next = 1'b0;
        if (!dm_wen_i) begin
            if (w_ll_grant || !w_any_valid) begin
                w_cnt_next = 4'd0;
            end else begin
                w_cnt_next = r_starve_cnt + 4'd1;
            end
            if (w_cnt_next == 4'(STARVE_LIMIT)) begin
                w_stall_next = 1'b1;
                w_cnt_next   = 4'd0;
            end
        end
    end

    // Scoreboard set/clear decode; x0 is never pending, and set beats clear
    always_comb begin
        w_gpr_set = '0;
        w_fpr_set = '0;
        w_gpr_clr = '0;
        w_fpr_clr = '0;
        if (iss_valid_i) begin
            if (iss_fpu_i) begin
                w_fpr_set = c_NUM_REGS'(1) << iss_wa_i;
            end else begin
                w_gpr_set = (c_NUM_REGS'(1) << iss_wa_i) & ~c_NUM_REGS'(1);
            end
        end
        if (w_ll_grant) begin
            if (w_ll_fpu) begin
                w_fpr_clr = c_NUM_REGS'(1) << w_ll_wa;
            end else begin
                w_gpr_clr = c_NUM_REGS'(1) << w_ll_wa;
            end
        end
    end

    // State registers: round-robin pointer, starvation guard, scoreboard
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr     <= '0;
            r_starve_cnt <= 4'd0;
            r_stall      <= 1'b0;
            r_gpr_pend   <= '0;
            r_fpr_pend   <= '0;
        end else begin
            if (w_ll_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
            r_starve_cnt <= w_cnt_next;
            r_stall      <= w_stall_next;
            r_gpr_pend   <= ((r_gpr_pend & ~w_gpr_clr) | w_gpr_set) & ~c_NUM_REGS'(1);
            r_fpr_pend   <= (r_fpr_pend & ~w_fpr_clr) | w_fpr_set;
        end
    end

    assign stall_o    = r_stall;
    assign gpr_pend_o = r_gpr_pend;
    assign fpr_pend_o = r_fpr_pend;

endmodule
`default_nettype wire
